// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// seq_detect_ctrl : configurable serial pattern detector with saturating count
// Revision: 1.0
// ============================================================================
module seq_detect_ctrl #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               start,
  input  logic               stop,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               busy,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [MAX_LEN-1:0]   r_pat;
  logic [LEN_W-1:0]     r_len;
  logic                 r_ovl;
  logic [MAX_LEN-1:0]   r_hist;
  logic [LEN_W-1:0]     r_fill;
  logic [CNT_W-1:0]     r_count;
  logic                 r_det;
  logic                 r_cfg_err;

  logic                 w_xfer;
  logic                 w_legal;
  logic                 w_latch;
  logic                 w_clear;
  logic                 w_shift;
  logic                 w_match;
  logic [MAX_LEN-1:0]   w_mask;
  logic [MAX_LEN-1:0]   w_hist_nxt;
  logic [LEN_W-1:0]     w_fill_nxt;

  assign cfg_ready   = (r_state != RUN);
  assign busy        = (r_state == RUN);
  assign detected    = r_det;
  assign match_count = r_count;
  assign cfg_err     = r_cfg_err;

  assign w_xfer  = cfg_valid && cfg_ready;
  assign w_legal = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));

  assign w_hist_nxt = {r_hist[MAX_LEN-2:0], bit_in};
  assign w_fill_nxt = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_match = (w_fill_nxt >= r_len) && ((w_hist_nxt & w_mask) == (r_pat & w_mask));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Any config transfer in READY, legal or not, takes priority over start.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_clear     = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer && w_legal) begin
          w_latch     = 1'b1;
          w_state_nxt = READY;
        end
      end
      READY: begin
        if (w_xfer) begin
          w_latch = w_legal;
        end else if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = READY;
        end else if (bit_valid) begin
          w_shift = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat     <= '0;
      r_len     <= '0;
      r_ovl     <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
      r_det     <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && !w_legal;
      r_det     <= w_shift && w_match;
      if (w_latch) begin
        r_pat <= cfg_pattern;
        r_len <= cfg_len;
        r_ovl <= cfg_overlap;
      end
      if (w_clear) begin
        r_hist  <= '0;
        r_fill  <= '0;
        r_count <= '0;
      end
      if (w_shift) begin
        r_hist <= w_hist_nxt;
        if (w_match) begin
          if (r_count != {CNT_W{1'b1}}) begin
            r_count <= r_count + CNT_W'(1);
          end
          // Non-overlapping mode restarts the fill so old bits cannot re-match.
          r_fill <= r_ovl ? w_fill_nxt : '0;
        end else begin
          r_fill <= w_fill_nxt;
        end
      end
    end
  end

endmodule
`default_nettype wire
